map_389_core: RTL

MAP_389_CORE -- requirements
Module: map_389_core

---
 rtl/map_389_core_pkg.sv | 36 +++
 rtl/map_389_core_m2_wr_det.sv | 70 +++++++
 rtl/map_389_core.sv | 111 +++++++++++
 3 files changed

// File: rtl/map_389_core_pkg.sv
// Shared definitions for the map_389 mapper: register page decode, field positions,
// and the save-state register index map.
package map_389_core_pkg;

   // cpu_addr[14:12] page selecting the latched register (with cpu_addr[15] = 1)
   localparam logic [2:0] Reg0Page = 3'd0;
   localparam logic [2:0] Reg1Page = 3'd1;

   localparam int unsigned PrgOuterMsb = 5;
   localparam int unsigned PrgOuterLsb = 3;
   localparam int unsigned MirBit      = 0;
   localparam int unsigned ChrOuterMsb = 5;
   localparam int unsigned ChrOuterLsb = 2;
   localparam int unsigned ModeBit     = 1;
   localparam int unsigned PrgInnerMsb = 3;
   localparam int unsigned PrgInnerLsb = 2;
   localparam int unsigned ChrInnerMsb = 1;
   localparam int unsigned ChrInnerLsb = 0;

   // Cycles after reset until every synchronizer/history flop holds a real M2 sample
   localparam logic [2:0] FillDone = 3'd4;

   typedef enum logic [1:0] {
      SsReg0 = 2'd0,
      SsReg1 = 2'd1,
      SsReg2 = 2'd2,
      SsNone = 2'd3
   } ss_sel_e;

   function automatic ss_sel_e reg_sel(logic [2:0] page);
      if (page == Reg0Page) return SsReg0;
      if (page == Reg1Page) return SsReg1;
      return SsReg2;
   endfunction

endpackage

// File: rtl/map_389_core_m2_wr_det.sv
// M2 synchronizer with glitch filter, bus capture on rising edge, and a one-clk
// CPU write strobe on the filtered falling edge.
module map_389_core_m2_wr_det
   import map_389_core_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       map_rst,
   input  logic       m2,
   input  logic       cpu_rw,
   input  logic [3:0] cpu_hi,
   input  logic [7:0] cpu_lo,
   output logic       wr_stb,
   output logic [2:0] wr_page,
   output logic [7:0] wr_data
);

   logic       m2_s1_q, m2_s2_q, m2_h1_q, m2_h2_q, m2_f_q;
   logic [2:0] fill_q;
   logic       armed_q, seen_rise_q, cap_rw_q;
   logic [3:0] cap_hi_q;
   logic [7:0] cap_lo_q;
   logic       fill_done, stable_hi, stable_lo, rise, fall;

   // Three agreeing samples are needed to move the filtered M2, rejecting pulses < 2 clk
   assign fill_done = (fill_q == FillDone);
   assign stable_hi = m2_s2_q & m2_h1_q & m2_h2_q;
   assign stable_lo = ~(m2_s2_q | m2_h1_q | m2_h2_q);
   // A rise only counts once a genuine low has been seen since reset
   assign rise      = armed_q & stable_hi & ~m2_f_q;
   assign fall      = stable_lo & m2_f_q;

   assign wr_stb  = fall & seen_rise_q & ~cap_rw_q & cap_hi_q[3] & ~map_rst;
   assign wr_page = cap_hi_q[2:0];
   assign wr_data = cap_lo_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m2_s1_q     <= 1'b0;
         m2_s2_q     <= 1'b0;
         m2_h1_q     <= 1'b0;
         m2_h2_q     <= 1'b0;
         m2_f_q      <= 1'b0;
         fill_q      <= '0;
         armed_q     <= 1'b0;
         seen_rise_q <= 1'b0;
         cap_rw_q    <= 1'b0;
         cap_hi_q    <= '0;
         cap_lo_q    <= '0;
      end else begin
         m2_s1_q <= m2;
         m2_s2_q <= m2_s1_q;
         m2_h1_q <= m2_s2_q;
         m2_h2_q <= m2_h1_q;
         if (!fill_done) fill_q <= fill_q + 3'd1;
         if (fill_done && stable_lo) armed_q <= 1'b1;
         if (stable_hi) m2_f_q <= 1'b1;
         else if (stable_lo) m2_f_q <= 1'b0;
         if (rise) begin
            seen_rise_q <= 1'b1;
            cap_rw_q    <= cpu_rw;
            cap_hi_q    <= cpu_hi;
            cap_lo_q    <= cpu_lo;
         end else if (fall) begin
            seen_rise_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/map_389_core.sv
// Mapper 389 core: address-latched bank registers, PRG/CHR address generation,
// nametable mirroring and save-state access.
module map_389_core
   import map_389_core_pkg::*;
#(
   parameter int unsigned PRG_AW = 22,
   parameter int unsigned CHR_AW = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              map_rst,
   input  logic              m2,
   input  logic              cpu_rw,
   input  logic [15:0]       cpu_addr,
   input  logic [13:0]       ppu_addr,
   input  logic              ss_we,
   input  logic [1:0]        ss_addr,
   input  logic [7:0]        ss_wdat,
   output logic [7:0]        ss_rdat,
   output logic [PRG_AW-1:0] prg_addr,
   output logic              prg_ce,
   output logic [CHR_AW-1:0] chr_addr,
   output logic              ciram_a10,
   output logic              ciram_ce
);

   logic       wr_stb;
   logic [2:0] wr_page;
   logic [7:0] wr_data;
   logic [7:0] reg0_q, reg1_q, reg2_q;

   logic [2:0]  prg_outer;
   logic [1:0]  prg_inner, chr_inner;
   logic [3:0]  chr_outer;
   logic        mir, mode;
   logic [4:0]  bank16;
   logic [18:0] prg_nat, chr_nat;

   map_389_core_m2_wr_det u_m2_wr_det (
      .clk     (clk),
      .rst_n   (rst_n),
      .map_rst (map_rst),
      .m2      (m2),
      .cpu_rw  (cpu_rw),
      .cpu_hi  (cpu_addr[15:12]),
      .cpu_lo  (cpu_addr[7:0]),
      .wr_stb  (wr_stb),
      .wr_page (wr_page),
      .wr_data (wr_data)
   );

   // Save-state restore has priority over a CPU write landing in the same clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg0_q <= '0;
         reg1_q <= '0;
         reg2_q <= '0;
      end else if (map_rst) begin
         reg0_q <= '0;
         reg1_q <= '0;
         reg2_q <= '0;
      end else if (ss_we) begin
         case (ss_sel_e'(ss_addr))
            SsReg0:  reg0_q <= ss_wdat;
            SsReg1:  reg1_q <= ss_wdat;
            SsReg2:  reg2_q <= ss_wdat;
            default: ;
         endcase
      end else if (wr_stb) begin
         case (reg_sel(wr_page))
            SsReg0:  reg0_q <= wr_data;
            SsReg1:  reg1_q <= wr_data;
            default: reg2_q <= wr_data;
         endcase
      end
   end

   always_comb begin
      ss_rdat = 8'h00;
      case (ss_sel_e'(ss_addr))
         SsReg0:  ss_rdat = reg0_q;
         SsReg1:  ss_rdat = reg1_q;
         SsReg2:  ss_rdat = reg2_q;
         default: ss_rdat = 8'h00;
      endcase
   end

   assign prg_outer = reg0_q[PrgOuterMsb:PrgOuterLsb];
   assign mir       = reg0_q[MirBit];
   assign chr_outer = reg1_q[ChrOuterMsb:ChrOuterLsb];
   assign mode      = reg1_q[ModeBit];
   assign prg_inner = reg2_q[PrgInnerMsb:PrgInnerLsb];
   assign chr_inner = reg2_q[ChrInnerMsb:ChrInnerLsb];

   // Upper 16K window is fixed to the last inner bank of the outer block
   assign bank16 = cpu_addr[14] ? {prg_outer, 2'b11} : {prg_outer, prg_inner};

   always_comb begin
      prg_nat = '0;
      if (mode) prg_nat = {bank16, cpu_addr[13:0]};
      else      prg_nat = {1'b0, prg_outer, cpu_addr[14:0]};
   end

   assign chr_nat   = {chr_outer, chr_inner, ppu_addr[12:0]};
   assign prg_addr  = PRG_AW'(prg_nat);
   assign chr_addr  = CHR_AW'(chr_nat);
   assign prg_ce    = cpu_addr[15];
   assign ciram_a10 = mir ? ppu_addr[11] : ppu_addr[10];
   assign ciram_ce  = ~ppu_addr[13];

endmodule
